// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receive path: dual-pointer memory, fill level and
// registered empty/full flags, with a registered read port.
module uart_rx_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          full_q,   full_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, which is what lets a read of the full slot return the
  // old byte while the same slot is being overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and leaving it unreset keeps it RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer: accepts receiver strobes into a FIFO, serves the
// consumer on a registered read handshake and keeps a sticky overrun flag.
module uart_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxDone,
  input  logic [7:0]    rxData,
  input  logic          rdReq,
  output logic [7:0]    dataOut,
  output logic          dataValid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clrOverrun
);

  if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_bad_depth
    $error("uart_rx_buffer: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  logic rd_accept;
  logic wr_accept;
  logic drop;
  logic overrun_q, overrun_d;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_accept = rdReq & ~empty;
    wr_accept = rxDone & (~full | rd_accept);
    drop      = rxDone & full & ~rd_accept;

    overrun_d = overrun_q;
    if (clrOverrun) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_accept),
    .wr_data  (rxData),
    .rd_en    (rd_accept),
    .rd_data  (dataOut),
    .rd_valid (dataValid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign overrun = overrun_q;

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte buffer between the UART receiver and the consuming logic. It captures every byte the receiver strobes out into an internal FIFO and hands the bytes to the consumer on a registered read-request/data-valid handshake. It reports empty, full and fill level, and keeps a sticky overrun flag for bytes that arrived while the FIFO was full. It is the receive-direction counterpart of the buffered UART transmit path.

## Interface
- `DEPTH`, default 64: FIFO depth in bytes; must be a power of two, at least 2.
- `AW`, default 6: address width, log2(`DEPTH`).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `rxDone` in 1: one-cycle strobe from the UART receiver; `rxData` is valid in that cycle.
- `rxData` in 8: received byte.
- `rdReq` in 1: consumer read request, sampled every cycle.
- `dataOut` out 8: byte returned for an accepted read.
- `dataValid` out 1: one-cycle pulse; `dataOut` is valid in that cycle.
- `empty` out 1: FIFO holds 0 bytes.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `count` out `AW`+1: current fill level, 0..`DEPTH`.
- `overrun` out 1: sticky; a byte was dropped.
- `clrOverrun` in 1: clears `overrun`.

## Operation
- **Write.** When `rxDone` is high and the FIFO is not full, `rxData` is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- **Dropped write.** When `rxDone` is high, the FIFO is full, and there is no accepted read in the same cycle, the byte is dropped and `overrun` is set.
- **Read.** A read is accepted when `rdReq` is high and the FIFO is not empty. The byte at `rd_ptr` is registered into `dataOut`, `dataValid` is 1 in the next cycle, and `rd_ptr` increments modulo `DEPTH`.
- **Ignored read.** `rdReq` while empty is ignored: no pulse, and `dataOut` holds its last value.
- **Write while full with a read.** `rxDone` and an accepted read in the same cycle while full: both are performed, `count` stays `DEPTH`, and `overrun` is not set.
- **Write while empty with a read.** `rxDone` and `rdReq` in the same cycle while empty: only the write occurs. The read is not accepted and there is no pass-through.
- **Simultaneous write and read otherwise.** Both occur and `count` is unchanged.
- **Count.** `count` is +1 on a write only, −1 on a read only, and unchanged otherwise. It is `AW`+1 bits wide so that `DEPTH` is representable.
- **Flags.** `empty` = (`count`==0) and `full` = (`count`==`DEPTH`). Both are registered and reflect the state after each edge.
- **Overrun priority.** Setting `overrun` wins over `clrOverrun` in the same cycle.
- **Back-to-back reads.** `rdReq` may be held high continuously. One byte is delivered per cycle until the FIFO is empty.

## Timing
- **Reset values.** `dataOut`=0, `dataValid`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0. Both pointers are 0 and memory contents are don't-care.
- **Reset mid-operation.** This discards all buffered bytes. The `rxDone` and `rdReq` present in the reset cycle are ignored.
- **Write latency.** A byte written at edge N updates `empty`/`count` after edge N. It is readable by an `rdReq` sampled at edge N+1, and `dataValid` follows at N+2.
- **Read latency.** 1 cycle from an accepted `rdReq` to `dataValid`.
- **Throughput.** One write and one read per cycle; no stalls.
- **Pointer wrap.** After `DEPTH` writes, `wr_ptr` returns to 0 with no gap and no lost byte.

## Structure
- **No package.** The block has no shared typedefs.
- **`DEPTH`/`AW` consistency.** Checked by an elaboration-time assertion.
- **Sub-module `uart_rx_fifo`.**
  - Contains the dual-pointer memory, pointer and count logic, and the `empty`/`full` flags.
  - Has a registered read port.
- **Top level** holds the write/read accept logic and the overrun register.

## Test plan
- **Single byte.** After reset, `rxDone` with 0xA5, then `rdReq` one cycle later → `dataValid` pulse with `dataOut`=0xA5; `count` goes 0→1→0; `empty` returns to 1.
- **Fill, overflow, drain.**
  - Write 64 bytes 0x00..0x3F → `full`=1, `count`=64.
  - A 65th write of 0xFF → dropped, `overrun`=1.
  - Drain → 0x00..0x3F in order, with no 0xFF.
- **Full with simultaneous read and write.** While full, `rdReq` and `rxDone`(0x77) in the same cycle → 0x00 returned, `count` stays 64, `overrun` stays 0. 0x77 is read last.
- **Empty with simultaneous read and write.** While empty, `rxDone`(0x11) and `rdReq` in the same cycle → no `dataValid`, `count`=1. The next `rdReq` returns 0x11.
- **Wrap-around under streaming.** Stream 200 bytes with `rdReq` held high and writes every third cycle → every byte is returned in order, `count` ≤ 2, and `overrun`=0.
- **Reset mid-stream, and overrun priority.**
  - Assert `rst` with 10 bytes buffered → next cycle `empty`=1, `count`=0, `dataValid`=0.
  - `clrOverrun` in the same cycle as a dropped write → `overrun` remains 1.
